// File: rtl/t_bft_pkg.sv
// Shared types and helpers for the T-switch BFT network and its client NICs.
package t_bft_pkg;

  function automatic int addr_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int N_DEF = 8;
  localparam int A_W_DEF = 4;
  localparam int D_W_DEF = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [A_W_DEF-1:0] addr;
    logic [D_W_DEF-1:0] data;
    logic               defl;
  } pkt_t;

  typedef enum logic [1:0] {
    NONE,
    LEFT,
    RIGHT,
    U0
  } sel_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/t_client_fifo.sv
// Synchronous injection FIFO for the client NIC.
// Push is refused when full, pop is refused when empty.
module t_client_fifo
  import t_bft_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/t_client_nic.sv
// Client NIC for the deflection-routed BFT: injects, ejects, recirculates.
// Stats counters are built only when TCLIENT_STATS_EN is defined.
module t_client_nic
  import t_bft_pkg::*;
#(
  parameter int N     = 8,
  parameter int A_W   = addr_w(N),
  parameter int D_W   = 32,
  parameter int POSX  = 0,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           c_i_v,
  output logic           c_i_rdy,
  input  logic [A_W-1:0] c_i_addr,
  input  logic [D_W-1:0] c_i_data,
  output logic           n_o_v,
  output logic           n_o_defl,
  output logic [A_W-1:0] n_o_addr,
  output logic [D_W-1:0] n_o_data,
  input  logic           n_i_v,
  input  logic           n_i_defl,
  input  logic [A_W-1:0] n_i_addr,
  input  logic [D_W-1:0] n_i_data,
  output logic           c_o_v,
  output logic           c_o_defl,
  output logic [D_W-1:0] c_o_data,
  output logic [15:0]    inj_cnt,
  output logic [15:0]    ej_cnt,
  output logic [15:0]    defl_cnt
);

  localparam logic [A_W-1:0] POS = A_W'(POSX);

  typedef struct packed {
    logic [A_W-1:0] addr;
    logic [D_W-1:0] data;
  } flit_t;

  flit_t head;
  flit_t rc;
  logic  rc_v;
  logic  full;
  logic  empty;
  logic  push;
  logic  pop;
  logic  hit;
  logic  miss;

  assign c_i_rdy = ce & ~rst & ~full;
  assign push    = c_i_v & c_i_rdy;
  assign pop     = ce & ~rst & ~rc_v & ~empty;
  assign hit     = n_i_v & (n_i_addr == POS);
  assign miss    = n_i_v & (n_i_addr != POS);

  t_client_fifo #(
    .DEPTH(DEPTH),
    .W    (A_W + D_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  ({c_i_addr, c_i_data}),
    .full (full),
    .empty(empty),
    .dout (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_v     <= 1'b0;
      rc       <= '0;
      n_o_v    <= 1'b0;
      n_o_defl <= 1'b0;
      n_o_addr <= '0;
      n_o_data <= '0;
      c_o_v    <= 1'b0;
      c_o_defl <= 1'b0;
      c_o_data <= '0;
    end else if (ce) begin
      c_o_v <= hit;
      if (hit) begin
        c_o_defl <= n_i_defl;
        c_o_data <= n_i_data;
      end
      rc_v <= miss;
      if (miss) begin
        rc.addr <= n_i_addr;
        rc.data <= n_i_data;
      end
      // Recirculation wins: it must drain every cycle to never overflow.
      if (rc_v) begin
        n_o_v    <= 1'b1;
        n_o_defl <= 1'b1;
        n_o_addr <= rc.addr;
        n_o_data <= rc.data;
      end else if (!empty) begin
        n_o_v    <= 1'b1;
        n_o_defl <= 1'b0;
        n_o_addr <= head.addr;
        n_o_data <= head.data;
      end else begin
        n_o_v    <= 1'b0;
        n_o_defl <= 1'b0;
      end
    end
  end

`ifdef TCLIENT_STATS_EN
  logic [15:0] inj_q;
  logic [15:0] ej_q;
  logic [15:0] defl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_q  <= '0;
      ej_q   <= '0;
      defl_q <= '0;
    end else if (ce) begin
      if (pop)  inj_q  <= sat_inc(inj_q);
      if (hit)  ej_q   <= sat_inc(ej_q);
      if (rc_v) defl_q <= sat_inc(defl_q);
    end
  end

  assign inj_cnt  = inj_q;
  assign ej_cnt   = ej_q;
  assign defl_cnt = defl_q;
`else
  assign inj_cnt  = '0;
  assign ej_cnt   = '0;
  assign defl_cnt = '0;
`endif

endmodule

// File: tb/tb_t_client_nic.sv
// Randomized bench for t_client_nic against a queue-based packet model.
module tb_t_client_nic;

  localparam int N     = 8;
  localparam int A_W   = 4;
  localparam int D_W   = 32;
  localparam int POSX  = 3;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           ce;
  logic           c_i_v;
  logic           c_i_rdy;
  logic [A_W-1:0] c_i_addr;
  logic [D_W-1:0] c_i_data;
  logic           n_o_v;
  logic           n_o_defl;
  logic [A_W-1:0] n_o_addr;
  logic [D_W-1:0] n_o_data;
  logic           n_i_v;
  logic           n_i_defl;
  logic [A_W-1:0] n_i_addr;
  logic [D_W-1:0] n_i_data;
  logic           c_o_v;
  logic           c_o_defl;
  logic [D_W-1:0] c_o_data;
  logic [15:0]    inj_cnt;
  logic [15:0]    ej_cnt;
  logic [15:0]    defl_cnt;

  always #5 clk = ~clk;

  t_client_nic #(
    .N    (N),
    .A_W  (A_W),
    .D_W  (D_W),
    .POSX (POSX),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .c_i_v   (c_i_v),
    .c_i_rdy (c_i_rdy),
    .c_i_addr(c_i_addr),
    .c_i_data(c_i_data),
    .n_o_v   (n_o_v),
    .n_o_defl(n_o_defl),
    .n_o_addr(n_o_addr),
    .n_o_data(n_o_data),
    .n_i_v   (n_i_v),
    .n_i_defl(n_i_defl),
    .n_i_addr(n_i_addr),
    .n_i_data(n_i_data),
    .c_o_v   (c_o_v),
    .c_o_defl(c_o_defl),
    .c_o_data(c_o_data),
    .inj_cnt (inj_cnt),
    .ej_cnt  (ej_cnt),
    .defl_cnt(defl_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [A_W-1:0] a;
    logic [D_W-1:0] d;
  } pk_t;

  pk_t            q[$];
  bit             rcv;
  pk_t            rc;
  bit             e_nov;
  bit             e_ndefl;
  logic [A_W-1:0] e_na;
  logic [D_W-1:0] e_nd;
  bit             e_cov;
  bit             e_cdefl;
  logic [D_W-1:0] e_cd;
  int             n_inj;
  int             n_ej;
  int             n_defl;

  function automatic logic [15:0] exp_cnt(input int v);
`ifdef TCLIENT_STATS_EN
    return (v > 65535) ? 16'hFFFF : 16'(v);
`else
    return (v < 0) ? 16'hFFFF : 16'h0;
`endif
  endfunction

  // One clock: check ready, advance the model at the edge, compare outputs.
  task automatic step();
    bit  rdy;
    pk_t p;
    #1;
    rdy = ce && !rst && (q.size() < DEPTH);
    check("c_i_rdy", c_i_rdy, rdy);
    @(posedge clk);
    if (rst) begin
      q.delete();
      rcv = 0;
      e_nov = 0;
      e_ndefl = 0;
      e_cov = 0;
      n_inj = 0;
      n_ej = 0;
      n_defl = 0;
    end else if (ce) begin
      if (rcv) begin
        e_nov = 1;
        e_ndefl = 1;
        e_na = rc.a;
        e_nd = rc.d;
        n_defl++;
      end else if (q.size() > 0) begin
        p = q.pop_front();
        e_nov = 1;
        e_ndefl = 0;
        e_na = p.a;
        e_nd = p.d;
        n_inj++;
      end else begin
        e_nov = 0;
        e_ndefl = 0;
      end
      if (c_i_v && rdy) q.push_back('{c_i_addr, c_i_data});
      e_cov = n_i_v && (n_i_addr == A_W'(POSX));
      if (e_cov) begin
        e_cd = n_i_data;
        e_cdefl = n_i_defl;
        n_ej++;
      end
      rcv = n_i_v && (n_i_addr != A_W'(POSX));
      if (rcv) rc = '{n_i_addr, n_i_data};
    end
    #1;
    check("n_o_v", n_o_v, e_nov);
    if (e_nov) begin
      check("n_o_defl", n_o_defl, e_ndefl);
      check("n_o_addr", n_o_addr, e_na);
      check("n_o_data", n_o_data, e_nd);
    end
    check("c_o_v", c_o_v, e_cov);
    if (e_cov) begin
      check("c_o_defl", c_o_defl, e_cdefl);
      check("c_o_data", c_o_data, e_cd);
    end
    check("inj_cnt", inj_cnt, exp_cnt(n_inj));
    check("ej_cnt", ej_cnt, exp_cnt(n_ej));
    check("defl_cnt", defl_cnt, exp_cnt(n_defl));
  endtask

  task automatic quiet();
    c_i_v = 0;
    n_i_v = 0;
    n_i_defl = 0;
  endtask

  initial begin
    rst = 1;
    ce = 1;
    c_i_v = 0;
    c_i_addr = '0;
    c_i_data = '0;
    n_i_v = 0;
    n_i_defl = 0;
    n_i_addr = '0;
    n_i_data = '0;
    rcv = 0;
    n_inj = 0;
    n_ej = 0;
    n_defl = 0;

    step();
    step();
    check("rst_n_o_addr", n_o_addr, 0);
    check("rst_n_o_data", n_o_data, 0);
    check("rst_n_o_defl", n_o_defl, 0);
    check("rst_c_o_data", c_o_data, 0);
    check("rst_c_o_defl", c_o_defl, 0);
    rst = 0;
    step();
    step();
    check("idle_rdy", c_i_rdy, 1);

    // injection latency
    c_i_v = 1;
    c_i_addr = 4'd5;
    c_i_data = 32'hA5A5_0001;
    step();
    quiet();
    step();
    check("lat_v", n_o_v, 1);
    check("lat_addr", n_o_addr, 5);
    check("lat_data", n_o_data, 32'hA5A5_0001);
    check("lat_defl", n_o_defl, 0);
    repeat (2) step();

    // six back-to-back pushes
    for (int i = 0; i < 6; i++) begin
      c_i_v = 1;
      c_i_addr = A_W'(i);
      c_i_data = 32'hB000_0000 + i;
      step();
    end
    quiet();
    repeat (8) step();

    // ejection
    n_i_v = 1;
    n_i_addr = 4'd3;
    n_i_defl = 1;
    n_i_data = 32'h1234;
    step();
    quiet();
    check("ej_v", c_o_v, 1);
    check("ej_defl", c_o_defl, 1);
    check("ej_data", c_o_data, 32'h1234);
    step();

    // misroute concurrent with a push: recirculation goes first
    c_i_v = 1;
    c_i_addr = 4'd2;
    c_i_data = 32'hC0;
    n_i_v = 1;
    n_i_addr = 4'd6;
    n_i_data = 32'hD6;
    step();
    quiet();
    step();
    check("rc_first_defl", n_o_defl, 1);
    check("rc_first_addr", n_o_addr, 6);
    step();
    check("fifo_next_v", n_o_v, 1);
    check("fifo_next_defl", n_o_defl, 0);
    check("fifo_next_addr", n_o_addr, 2);
    repeat (2) step();

    // fill FIFO while recirculation blocks pops, then reset
    for (int i = 0; i < 6; i++) begin
      c_i_v = 1;
      c_i_addr = 4'd1;
      c_i_data = 32'hF000 + i;
      n_i_v = 1;
      n_i_addr = 4'd7;
      n_i_data = 32'hE000 + i;
      step();
    end
    check("full_rdy", c_i_rdy, 0);
    quiet();
    rst = 1;
    step();
    check("rst_flush_v", n_o_v, 0);
    check("rst_flush_cov", c_o_v, 0);
    rst = 0;
    step();
    check("post_rst_v", n_o_v, 0);

    // ce low freezes everything
    c_i_v = 1;
    c_i_addr = 4'd4;
    c_i_data = 32'h4444;
    step();
    quiet();
    step();
    ce = 0;
    c_i_v = 1;
    n_i_v = 1;
    n_i_addr = 4'd3;
    n_i_data = 32'h9999;
    repeat (3) step();
    check("ce_hold_v", n_o_v, 1);
    check("ce_hold_data", n_o_data, 32'h4444);
    check("ce_hold_cov", c_o_v, 0);
    ce = 1;
    quiet();
    repeat (3) step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      ce = ($urandom_range(0, 7) != 0);
      c_i_v = $urandom_range(0, 2) != 0;
      c_i_addr = A_W'($urandom);
      c_i_data = $urandom;
      n_i_v = $urandom_range(0, 1) != 0;
      n_i_defl = $urandom_range(0, 1) != 0;
      n_i_addr = ($urandom_range(0, 2) == 0) ? 4'd3 : A_W'($urandom);
      n_i_data = $urandom;
      step();
    end
    rst = 0;
    ce = 1;
    quiet();
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
